uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_select.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART TX byte-path arbiter.
package uart_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_XFER = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_DATA_BITS      = 8;
   localparam int DEF_MAX_BURST      = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request searching upward from last_i+1, wrapping.
module rr_select #(
   parameter int NumReq = 4,
   parameter int IdxW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdxW-1:0]   last_i,
   output logic [IdxW-1:0]   grant_o,
   output logic              any_valid_o
);

   logic [IdxW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest set request wins.
   always_comb begin
      grant_o     = '0;
      cand        = '0;
      any_valid_o = |req_i;
      for (int off = NumReq; off >= 1; off--) begin
         cand = IdxW'((int'(last_i) + off) % NumReq);
         if (req_i[cand]) begin
            grant_o = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte path among NumReq requesters, with burst limit.
// Defining UART_ARB_TIMEOUT_EN adds a stall counter that revokes a grant whose owner goes quiet.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NumReq        = DEF_NUM_REQ,
   parameter int DataBits      = DEF_DATA_BITS,
   parameter int MaxBurst      = DEF_MAX_BURST,
   parameter int TimeoutCycles = DEF_TIMEOUT_CYCLES
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [NumReq-1:0]            ReqValid,
   input  logic [NumReq*DataBits-1:0]   ReqByte,
   input  logic [NumReq-1:0]            ReqLast,
   output logic [NumReq-1:0]            ReqReady,
   output logic [DataBits-1:0]          TxByte,
   output logic                         TxValid,
   input  logic                         TxReady,
   output logic [$clog2(NumReq)-1:0]    Owner,
   output logic                         Busy,
   output logic                         Timeout
);

   localparam int IW = $clog2(NumReq);
   localparam int BW = $clog2(MaxBurst + 1);

   if (NumReq < 2 || MaxBurst < 1 || TimeoutCycles < 1) begin : g_param_check
      $error("uart_tx_arbiter: illegal parameter combination");
   end

   arb_state_e          state_q, state_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic [IW-1:0]       last_q, last_d;
   logic [BW-1:0]       beat_q, beat_d;
   logic [IW-1:0]       rr_grant;
   logic                rr_any;
   logic [DataBits-1:0] req_bytes [NumReq];
   logic                own_valid, own_last, beat, burst_end, stall_expire;

   always_comb begin
      for (int k = 0; k < NumReq; k++) begin
         req_bytes[k] = ReqByte[k*DataBits +: DataBits];
      end
   end

   rr_select #(.NumReq(NumReq), .IdxW(IW)) u_rr_select (
      .req_i       (ReqValid),
      .last_i      (last_q),
      .grant_o     (rr_grant),
      .any_valid_o (rr_any)
   );

   assign own_valid = ReqValid[owner_q];
   assign own_last  = ReqLast[owner_q];
   assign beat      = (state_q == ARB_XFER) && own_valid && TxReady;
   assign burst_end = beat && (own_last || (beat_q == BW'(MaxBurst - 1)));

`ifdef UART_ARB_TIMEOUT_EN
   localparam int SW = $clog2(TimeoutCycles + 1);

   logic [SW-1:0] stall_q;
   logic          timeout_q;

   // Counts consecutive XFER cycles with the owner silent; expiry is the TimeoutCycles-th such cycle.
   assign stall_expire = (state_q == ARB_XFER) && !own_valid && (stall_q == SW'(TimeoutCycles - 1));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= stall_expire;
         if (state_q != ARB_XFER || own_valid || stall_expire) begin
            stall_q <= '0;
         end else begin
            stall_q <= stall_q + SW'(1);
         end
      end
   end

   assign Timeout = timeout_q;
`else
   assign stall_expire = 1'b0;
   assign Timeout      = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         last_q  <= IW'(NumReq - 1);
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      beat_d   = beat_q;
      TxValid  = 1'b0;
      TxByte   = '0;
      ReqReady = '0;
      Busy     = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (rr_any) begin
               state_d = ARB_XFER;
               owner_d = rr_grant;
               beat_d  = '0;
            end
         end
         ARB_XFER: begin
            if (beat) begin
               beat_d = beat_q + BW'(1);
            end
            if (burst_end || stall_expire) begin
               state_d = ARB_IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
      // Outputs are forced quiet while Reset is high so an abandoned grant completes no handshake.
      if (state_q == ARB_XFER && !Reset) begin
         Busy              = 1'b1;
         TxValid           = own_valid;
         TxByte            = req_bytes[owner_q];
         ReqReady[owner_q] = TxReady;
      end
   end

   assign Owner = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte sources, expected-beat queue and monitor.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DB = 8;
   localparam int MB = 16;
   localparam int TC = 8;

   logic             clk;
   logic             Reset;
   logic [NR-1:0]    ReqValid;
   logic [NR*DB-1:0] ReqByte;
   logic [NR-1:0]    ReqLast;
   logic [NR-1:0]    ReqReady;
   logic [DB-1:0]    TxByte;
   logic             TxValid;
   logic             TxReady;
   logic [1:0]       Owner;
   logic             Busy;
   logic             Timeout;

   uart_tx_arbiter #(
      .NumReq(NR), .DataBits(DB), .MaxBurst(MB), .TimeoutCycles(TC)
   ) dut (
      .Clk(clk), .Reset(Reset), .ReqValid(ReqValid), .ReqByte(ReqByte), .ReqLast(ReqLast),
      .ReqReady(ReqReady), .TxByte(TxByte), .TxValid(TxValid), .TxReady(TxReady),
      .Owner(Owner), .Busy(Busy), .Timeout(Timeout)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int          n_cmp   = 0;
   int          n_fail  = 0;
   int          n_beats = 0;
   logic [11:0] exp_q[$];
   int          beat_cyc[$];
   logic [11:0] mon_e;

   logic [8:0]  mem [NR][64];
   int          rd [NR];
   int          wr [NR];
   logic [NR-1:0] acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_inputs();
      for (int k = 0; k < NR; k++) begin
         if (rd[k] < wr[k]) begin
            ReqValid[k]          = 1'b1;
            ReqByte[k*DB +: DB]  = mem[k][rd[k]][7:0];
            ReqLast[k]           = mem[k][rd[k]][8];
         end else begin
            ReqValid[k]          = 1'b0;
            ReqByte[k*DB +: DB]  = '0;
            ReqLast[k]           = 1'b0;
         end
      end
   endtask

   task automatic load(input int k, input logic [7:0] b, input logic last);
      mem[k][wr[k]] = {last, b};
      wr[k]++;
      drive_inputs();
   endtask

   task automatic clear_src();
      for (int k = 0; k < NR; k++) begin
         rd[k] = 0;
         wr[k] = 0;
      end
      drive_inputs();
   endtask

   task automatic push_exp(input int owner, input logic [7:0] b);
      exp_q.push_back({4'(owner), b});
   endtask

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic wait_beats(input int n);
      int target;
      int g;
      target = n_beats + n;
      g = 0;
      while (n_beats < target && g < 500) begin
         @(posedge clk);
         #2;
         g++;
      end
      check("wait_beats_reached", 32'(n_beats >= target), 32'd1);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int g;
      g = 0;
      while ((exp_q.size() != 0 || Busy) && g < 1000) begin
         @(posedge clk);
         #2;
         g++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      #1;
   endtask

   // Sources pop on a handshake seen at the negedge before the active edge.
   initial begin
      ReqValid = '0;
      ReqByte  = '0;
      ReqLast  = '0;
      for (int k = 0; k < NR; k++) begin
         rd[k] = 0;
         wr[k] = 0;
      end
      forever begin
         @(negedge clk);
         acc = ReqValid & ReqReady;
         @(posedge clk);
         #1;
         for (int k = 0; k < NR; k++) begin
            if (acc[k]) rd[k]++;
         end
         drive_inputs();
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (TxValid && TxReady) begin
         n_beats++;
         beat_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_unexpected: got owner %0d byte %0h expected none", Owner, TxByte);
         end else begin
            mon_e = exp_q.pop_front();
            check("beat_owner_byte", {22'b0, Owner, TxByte}, {20'b0, mon_e});
            check("beat_ready", {28'b0, ReqReady}, 32'(4'b0001 << mon_e[9:8]));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      n_fail++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int base;
      int k;
      Reset   = 1'b1;
      TxReady = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_txvalid", TxValid, 0);
      check("rst_reqready", ReqReady, 0);
      check("rst_busy", Busy, 0);
      check("rst_timeout", Timeout, 0);
      check("rst_txbyte", TxByte, 0);
      check("rst_owner", Owner, 0);
      step();
      Reset = 1'b0;
      @(negedge clk);
      check("post_rst_busy", Busy, 0);
      check("post_rst_txvalid", TxValid, 0);

      // Simultaneous 0 and 2: requester 0 first, one IDLE cycle, then 2.
      step();
      base = beat_cyc.size();
      push_exp(0, 8'h10);
      push_exp(2, 8'h20);
      load(0, 8'h10, 1'b1);
      load(2, 8'h20, 1'b1);
      wait_drain("drain_pair");
      check("pair_gap", 32'(beat_cyc[base+1] - beat_cyc[base]), 32'd2);

      // Three-byte message on consecutive cycles.
      step();
      base = beat_cyc.size();
      push_exp(1, 8'hA1);
      push_exp(1, 8'hA2);
      push_exp(1, 8'hA3);
      load(1, 8'hA1, 1'b0);
      load(1, 8'hA2, 1'b0);
      load(1, 8'hA3, 1'b1);
      wait_drain("drain_msg3");
      check("msg3_gap1", 32'(beat_cyc[base+1] - beat_cyc[base]), 32'd1);
      check("msg3_gap2", 32'(beat_cyc[base+2] - beat_cyc[base+1]), 32'd1);
      @(negedge clk);
      check("msg3_idle", Busy, 0);

      // Burst cap: 16 beats of requester 3, then requester 0, then the rest of 3.
      step();
      base = beat_cyc.size();
      for (int i = 0; i < 16; i++) push_exp(3, 8'(8'h30 + i));
      push_exp(0, 8'h01);
      push_exp(0, 8'h02);
      for (int i = 16; i < 20; i++) push_exp(3, 8'(8'h30 + i));
      for (int i = 0; i < 20; i++) load(3, 8'(8'h30 + i), i == 19);
      load(0, 8'h01, 1'b0);
      load(0, 8'h02, 1'b1);
      wait_drain("drain_burst");
      check("burst_release_gap", 32'(beat_cyc[base+16] - beat_cyc[base+15]), 32'd2);

      // TxReady stall mid-burst holds the presented byte and owner.
      step();
      for (int i = 0; i < 10; i++) push_exp(2, 8'(8'h50 + i));
      for (int i = 0; i < 10; i++) load(2, 8'(8'h50 + i), i == 9);
      wait_beats(4);
      TxReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_txvalid", TxValid, 1);
         check("stall_txbyte", TxByte, 8'h54);
         check("stall_owner", Owner, 2);
      end
      step();
      TxReady = 1'b1;
      wait_drain("drain_stall");

      // Owner goes quiet after two bytes.
      step();
      push_exp(1, 8'h71);
      push_exp(1, 8'h72);
      load(1, 8'h71, 1'b0);
      load(1, 8'h72, 1'b0);
      wait_beats(2);
      load(0, 8'h80, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
      push_exp(0, 8'h80);
      k = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (Timeout) break;
      end
      check("timeout_cycle", 32'(k), 32'd9);
      check("timeout_busy", Busy, 0);
      check("timeout_owner", Owner, 1);
      @(negedge clk);
      check("timeout_pulse_width", Timeout, 0);
      wait_drain("drain_after_timeout");
      step();
      push_exp(1, 8'h73);
      load(1, 8'h73, 1'b1);
      wait_drain("drain_resume");
`else
      k = 0;
      repeat (20) begin
         @(negedge clk);
         k = k + int'(Timeout);
      end
      check("hold_busy", Busy, 1);
      check("hold_owner", Owner, 1);
      check("hold_txvalid", TxValid, 0);
      check("hold_no_timeout", 32'(k), 32'd0);
      step();
      push_exp(1, 8'h73);
      push_exp(0, 8'h80);
      load(1, 8'h73, 1'b1);
      wait_drain("drain_resume");
`endif

      // Reset mid-burst: only the four completed bytes count, then requester 0 has priority.
      step();
      for (int i = 0; i < 4; i++) push_exp(3, 8'(8'h60 + i));
      for (int i = 0; i < 10; i++) load(3, 8'(8'h60 + i), i == 9);
      wait_beats(4);
      Reset = 1'b1;
      clear_src();
      @(negedge clk);
      check("midrst_txvalid", TxValid, 0);
      check("midrst_reqready", ReqReady, 0);
      check("midrst_busy", Busy, 0);
      check("midrst_txbyte", TxByte, 0);
      check("midrst_timeout", Timeout, 0);
      step();
      Reset = 1'b0;
      @(negedge clk);
      check("after_rst_busy", Busy, 0);
      check("after_rst_owner", Owner, 0);
      check("after_rst_txvalid", TxValid, 0);
      step();
      push_exp(0, 8'h90);
      push_exp(2, 8'h92);
      load(2, 8'h92, 1'b1);
      load(0, 8'h90, 1'b1);
      wait_drain("drain_after_rst");

      repeat (3) @(posedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
